// File: rtl/pg_share_encoder.sv
// -----------------------------------------------------------------------------
// pg_share_encoder
//
// Producer-side masking encoder for the masked propagate/generate stage.
// Splits plaintext operands a and b into first-order Boolean shares
// (a = a0 ^ a1, b = b0 ^ b1) and pairs every share set with a fresh refresh
// mask rN. All masks come from an internal free-running Fibonacci LFSR.
//
// Handshake (both sides): a beat transfers on a rising edge where valid and
// ready are both high. A source holds valid and its data stable until the beat
// transfers. o_rdy depends only on the FSM state, o_vld and i_rdy (never on
// i_vld), and there is exactly one output register stage between them.
//
// Ports
//   i_clk        clock, all state on the rising edge
//   i_rst        synchronous active-high reset
//   i_seed       (PG_RESEED_EN only) new LFSR value; 0 is replaced by SEED
//   i_seed_vld   (PG_RESEED_EN only) load i_seed and re-enter warm-up
//   i_a, i_b     plaintext operands
//   i_vld        input valid
//   o_rdy        input ready
//   o_a0, o_a1   shares of a (a ^ ma, ma)
//   o_b0, o_b1   shares of b (b ^ mb, mb)
//   o_rN         fresh refresh mask, one bit per bit-slice
//   o_vld        output valid
//   i_rdy        downstream ready
//   o_dbg_state  FSM state (0 = WARM, 1 = RUN)
//
// Configuration macro: PG_RESEED_EN adds the runtime reseed ports. Without it
// the LFSR is reloaded only by i_rst.
// -----------------------------------------------------------------------------
module pg_share_encoder #(
  parameter int          WIDTH  = 8,
  parameter int          LFSR_W = 32,
  parameter logic [31:0] SEED   = 32'hACE1_2468,
  parameter int          WARMUP = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef PG_RESEED_EN
  input  logic [LFSR_W-1:0] i_seed,
  input  logic              i_seed_vld,
`endif
  input  logic [WIDTH-1:0]  i_a,
  input  logic [WIDTH-1:0]  i_b,
  input  logic              i_vld,
  output logic              o_rdy,
  output logic [WIDTH-1:0]  o_a0,
  output logic [WIDTH-1:0]  o_a1,
  output logic [WIDTH-1:0]  o_b0,
  output logic [WIDTH-1:0]  o_b1,
  output logic [WIDTH-1:0]  o_rN,
  output logic              o_vld,
  input  logic              i_rdy,
  output logic              o_dbg_state
);

  // Maximal-length tap masks; bit k-1 set for each term x^k of the polynomial.
  localparam logic [63:0] TAPS64 =
      (LFSR_W == 24) ? 64'h0000_0000_00E1_0000 :  // x^24+x^23+x^22+x^17+1
      (LFSR_W == 32) ? 64'h0000_0000_8020_0003 :  // x^32+x^22+x^2+x+1
      (LFSR_W == 48) ? 64'h0000_C000_0018_0000 :  // x^48+x^47+x^21+x^20+1
      (LFSR_W == 64) ? 64'hD800_0000_0000_0000 :  // x^64+x^63+x^61+x^60+1
                       64'h0;
  localparam logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS64);
  localparam logic [LFSR_W-1:0] SEED_W = LFSR_W'(SEED);
  localparam int                CNT_W  = $clog2(WARMUP + 1);
  localparam logic [CNT_W-1:0]  WARM_LAST = CNT_W'(WARMUP - 1);

  // Elaboration-time parameter sanity.
  if (LFSR_W < 3 * WIDTH) begin : g_bad_width
    $error("pg_share_encoder: LFSR_W must be >= 3*WIDTH");
  end
  if (TAPS64 == 64'h0) begin : g_bad_taps
    $error("pg_share_encoder: no tap set for this LFSR_W (use 24, 32, 48 or 64)");
  end
  if (SEED_W == '0) begin : g_bad_seed
    $error("pg_share_encoder: SEED truncated to LFSR_W must be nonzero");
  end
  if (WARMUP < 1) begin : g_bad_warmup
    $error("pg_share_encoder: WARMUP must be >= 1");
  end

  typedef enum logic {
    ST_WARM = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   warm_cnt_q;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_step;
  logic               reseed;
  logic [LFSR_W-1:0]  reseed_val;
  logic [WIDTH-1:0]   ma, mb, mr;
  logic               accept;
  logic               drain;

`ifdef PG_RESEED_EN
  assign reseed     = i_seed_vld;
  assign reseed_val = (i_seed == '0) ? SEED_W : i_seed;
`else
  assign reseed     = 1'b0;
  assign reseed_val = SEED_W;
`endif

  // An all-zero LFSR would lock up; it is only reachable by a fault, so the
  // guard simply restarts the sequence from SEED.
  assign lfsr_step = (lfsr_q == '0) ? SEED_W
                                    : {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};

  // Masks are taken from the current (pre-step) LFSR value.
  assign ma = lfsr_q[WIDTH-1:0];
  assign mb = lfsr_q[2*WIDTH-1:WIDTH];
  assign mr = lfsr_q[3*WIDTH-1:2*WIDTH];

  // LFSR steps every cycle, including warm-up and stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr_q <= SEED_W;
    end else if (reseed) begin
      lfsr_q <= reseed_val;
    end else begin
      lfsr_q <= lfsr_step;
    end
  end

  // FSM state register and warm-up counter.
  always_ff @(posedge i_clk) begin
    if (i_rst || reseed) begin
      state_q    <= ST_WARM;
      warm_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_WARM && warm_cnt_q != WARM_LAST) begin
        warm_cnt_q <= warm_cnt_q + 1'b1;
      end
    end
  end

  // Next state and input ready.
  always_comb begin
    state_d = state_q;
    o_rdy   = 1'b0;
    case (state_q)
      ST_WARM: begin
        if (warm_cnt_q == WARM_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        o_rdy = ~o_vld | i_rdy;
      end
      default: begin
        state_d = ST_WARM;
      end
    endcase
  end

  assign o_dbg_state = (state_q == ST_RUN);

  assign accept = i_vld & o_rdy;
  assign drain  = o_vld & i_rdy;

  // Output share registers. Plaintext is XORed with its mask before it reaches
  // any flop, so no register ever holds an unmasked operand.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_a0  <= '0;
      o_a1  <= '0;
      o_b0  <= '0;
      o_b1  <= '0;
      o_rN  <= '0;
      o_vld <= 1'b0;
    end else if (accept) begin
      o_a0  <= i_a ^ ma;
      o_a1  <= ma;
      o_b0  <= i_b ^ mb;
      o_b1  <= mb;
      o_rN  <= mr;
      o_vld <= 1'b1;
    end else if (drain) begin
      o_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pg_share_encoder.sv
module tb_pg_share_encoder;

  localparam int          WIDTH  = 8;
  localparam int          WARMUP = 16;
  localparam logic [31:0] SEED   = 32'hACE1_2468;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  i_a, i_b;
  logic        i_vld, i_rdy;
  logic        o_rdy, o_vld, o_dbg_state;
  logic [7:0]  o_a0, o_a1, o_b0, o_b1, o_rN;
`ifdef PG_RESEED_EN
  logic [31:0] i_seed;
  logic        i_seed_vld;
`endif

  pg_share_encoder #(
    .WIDTH (WIDTH),
    .LFSR_W(32),
    .SEED  (SEED),
    .WARMUP(WARMUP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef PG_RESEED_EN
    .i_seed     (i_seed),
    .i_seed_vld (i_seed_vld),
`endif
    .i_a        (i_a),
    .i_b        (i_b),
    .i_vld      (i_vld),
    .o_rdy      (o_rdy),
    .o_a0       (o_a0),
    .o_a1       (o_a1),
    .o_b0       (o_b0),
    .o_b1       (o_b1),
    .o_rN       (o_rN),
    .o_vld      (o_vld),
    .i_rdy      (i_rdy),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model ----------------
  // x^32+x^22+x^2+x+1, shifting left, new bit enters at bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    if (s == 32'h0) return SEED;
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  logic [31:0] m_lfsr;
  int          warm_n;

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= SEED;
      warm_n <= 0;
    end
`ifdef PG_RESEED_EN
    else if (i_seed_vld) begin
      m_lfsr <= (i_seed == 32'h0) ? SEED : i_seed;
      warm_n <= 0;
    end
`endif
    else begin
      m_lfsr <= lfsr_next(m_lfsr);
      if (warm_n < WARMUP) warm_n <= warm_n + 1;
    end
  end

  // ---------------- scoreboard ----------------
  logic [39:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle's inputs just after a falling edge, predict ready and the
  // transfer outcome, then check the registered outputs on the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
    logic [39:0] e;
    logic        run;
    i_vld = v;
    i_a   = a;
    i_b   = b;
    i_rdy = r;
    #1;
    run = (warm_n == WARMUP);
    check("rdy", o_rdy, run && (exp_q.size() == 0 || r));
    check("dbg_state", o_dbg_state, run);
    acc = v && o_rdy;
    if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
    if (acc) begin
      e = {a ^ m_lfsr[7:0], m_lfsr[7:0], b ^ m_lfsr[15:8], m_lfsr[15:8], m_lfsr[23:16]};
      exp_q.push_back(e);
    end
    @(negedge clk);
    check("vld", o_vld, exp_q.size() != 0);
    if (exp_q.size() != 0) check("shares", {o_a0, o_a1, o_b0, o_b1, o_rN}, exp_q[0]);
  endtask

  // One-cycle reset pulse; everything must be cleared on the following cycle.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("rst_vld", o_vld, 0);
    check("rst_rdy", o_rdy, 0);
    check("rst_shares", {o_a0, o_a1, o_b0, o_b1, o_rN}, 0);
  endtask

  // Hold i_vld high from the end of reset and count non-ready cycles.
  task automatic warmup(input logic [7:0] a, input logic [7:0] b);
    int waited;
    waited = 0;
    acc    = 1'b0;
    for (int k = 0; k < 40 && !acc; k++) begin
      cycle(1'b1, a, b, 1'b1);
      if (!acc) waited++;
    end
    check("warm_len", waited, WARMUP);
    check("rec_a", o_a0 ^ o_a1, a);
    check("rec_b", o_b0 ^ o_b1, b);
  endtask

  // ---------------- stimulus ----------------
  logic [39:0] snap;
  logic [23:0] prev_m;
  int          nv;

  initial begin
    i_a   = '0;
    i_b   = '0;
    i_vld = 1'b1;
    i_rdy = 1'b1;
`ifdef PG_RESEED_EN
    i_seed     = '0;
    i_seed_vld = 1'b0;
`endif
    do_reset();

    // Warm-up length and first recombination.
    warmup(8'h5A, 8'hC3);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);  // drain only

    // Stall: outputs frozen and ready low for 5 cycles.
    cycle(1'b1, 8'h11, 8'h22, 1'b1);
    snap = {o_a0, o_a1, o_b0, o_b1, o_rN};
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 8'h99, 8'h77, 1'b0);
      check("stall_hold", {o_a0, o_a1, o_b0, o_b1, o_rN}, snap);
    end
    cycle(1'b1, 8'h33, 8'h44, 1'b1);  // drain and accept together
    check("rec_a_after_stall", o_a0 ^ o_a1, 8'h33);
    check("rec_b_after_stall", o_b0 ^ o_b1, 8'h44);

    // Streaming: 100 back-to-back sets, masks change every set.
    nv     = 0;
    prev_m = {o_a1, o_b1, o_rN};
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 8'(i * 7 + 1), 8'(~i), 1'b1);
      if (o_vld) nv++;
      check("fresh_mask", {o_a1, o_b1, o_rN} != prev_m, 1);
      prev_m = {o_a1, o_b1, o_rN};
    end
    check("stream_cnt", nv, 100);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);

    // Reset while a set is pending and stalled.
    cycle(1'b1, 8'hA5, 8'h5A, 1'b1);
    cycle(1'b1, 8'h00, 8'h00, 1'b0);
    cycle(1'b1, 8'h00, 8'h00, 1'b0);
    do_reset();
    warmup(8'h3C, 8'h96);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);

`ifdef PG_RESEED_EN
    // Reseed with 0 restarts from SEED and re-enters warm-up.
    i_seed     = 32'h0;
    i_seed_vld = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    i_seed_vld = 1'b0;
    warmup(8'hF0, 8'h0F);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    // Reseed with 1: after 16 steps the LFSR holds 32'h0001_B6DB.
    i_seed     = 32'h1;
    i_seed_vld = 1'b1;
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
    i_seed_vld = 1'b0;
    warmup(8'h12, 8'h34);
    check("seed1_a1", o_a1, 8'hDB);
    check("seed1_b1", o_b1, 8'hB6);
    check("seed1_rN", o_rN, 8'h01);
    cycle(1'b0, 8'h00, 8'h00, 1'b1);
`endif

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
